uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Sits between the UART byte receiver and the butterfly stages of the FFT core.
- Assembles a stream of received bytes into one frame of N_POINTS complex samples: real byte, then imaginary byte.
- Stores each sample at its bit-reversed slot, so the first radix-2 stage can consume the frame in natural order.
- Hands the frame over with a valid/ready handshake and holds it stable until the core accepts it.

Parameters:
- N_POINTS, 8, samples per frame; power of two, 2..64.
- BYTE_W, 8, width of each received byte and of each real/imag half.
- TIMEOUT_CYCLES, 65535, idle clocks after which a partial frame is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte.
- rx_byte  in  BYTE_W  received byte.
- frame_data  out  N_POINTS*2*BYTE_W  flattened frame; slot k = bits [k*2*BYTE_W +: 2*BYTE_W], real part in the upper half, imag part in the lower half.
- frame_valid  out  1  frame complete and stable.
- frame_ready  in  1  FFT core accepts the frame.
- overrun  out  1  sticky flag: a byte arrived while a frame was being held.
- timeout_evt  out  1  one-cycle pulse: a partial frame was discarded.

Behaviour:
- Reset (rst low, asynchronous):
  - state=FILL, byte counter=0, idle counter=0.
  - frame_data=0, frame_valid=0, overrun=0, timeout_evt=0.
- All outputs are registered.
- Byte index b runs 0..2*N_POINTS-1. Sample index s=b>>1. Target slot = bitrev(s) over log2(N_POINTS) bits.
  - N=8 mapping: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
- Even b writes the real (upper) half of the slot; odd b writes the imag (lower) half.
- State FILL:
  - On rx_valid: write the byte, increment b, clear the idle counter.
  - When the last byte (b=2*N_POINTS-1) is written: b wraps to 0, state moves to HOLD, frame_valid=1 from the next cycle.
  - Latency: the last byte strobe at edge t gives frame_valid high after edge t.
  - frame_data content during FILL is don't-care to consumers.
- State HOLD:
  - frame_data is frozen and frame_valid stays 1.
  - On an edge with frame_ready=1: frame_valid=0 from the next cycle, state returns to FILL with b=0.
  - frame_ready is ignored outside HOLD.
- rx_valid during HOLD, including the accept cycle itself:
  - The byte is dropped and overrun is set.
  - overrun clears only on reset.
  - The dropped byte does not count toward the next frame.
- Timeout (FILL only, when b>0 and TIMEOUT_CYCLES>0):
  - The idle counter increments on each cycle without rx_valid.
  - On reaching TIMEOUT_CYCLES: b=0, idle counter=0, timeout_evt pulses for 1 cycle.
  - Already-written slots are not cleared.
  - rx_valid in the same cycle as the expiry wins: the byte is accepted and no timeout occurs.
- The idle counter is held at 0 when b=0 or in HOLD.
- A reset mid-frame or mid-HOLD discards everything and returns to reset values immediately.
- The block is not pipelined: at most one frame is buffered.

Test Plan:
- Reset, then 16 bytes 0x00..0x0F with frame_ready=0 -> frame_valid rises the cycle after the 16th strobe. Slot0=0x0001, slot4=0x0203, slot2=0x0405, slot6=0x0607, slot1=0x0809, slot5=0x0A0B, slot3=0x0C0D, slot7=0x0E0F.
- Hold frame_ready=0 for 50 cycles, then assert it for 1 cycle -> frame_data unchanged throughout; frame_valid low the cycle after the accept edge; the next 16 bytes form a new frame.
- Send byte 0xAA during HOLD, and another in the accept cycle -> overrun=1 and stays 1; both bytes absent from the next frame; the next frame's slot0 = its first two bytes.
- TIMEOUT_CYCLES=20: send 5 bytes, then idle 20 cycles -> timeout_evt pulses once; then 16 bytes 0x10..0x1F -> slot0=0x1011, slot7=0x1E1F, frame_valid=1.
- rx_valid coincides with the timeout-expiry cycle -> no timeout_evt; the byte lands as b=5 (imag half of slot bitrev(2)=2).
- Assert rst low after 9 bytes, asynchronously mid-cycle -> outputs zero immediately; after release, 16 fresh bytes give a correct frame with no carry-over.

Source files
------------

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Collects bytes from the UART receiver into one frame of N_POINTS complex
//   samples (real byte, then imaginary byte). Each sample lands in its
//   bit-reversed slot, so the first radix-2 butterfly stage can read the frame
//   in natural order. The finished frame is offered with frame_valid and held
//   frozen until frame_ready is seen.
//
//   Ports
//     clk          system clock
//     rst          asynchronous, active-low reset
//     rx_valid     one-cycle strobe, rx_byte carries a new byte
//     rx_byte      received byte
//     frame_data   flattened frame; slot k = [k*2*BYTE_W +: 2*BYTE_W],
//                  real in the upper half, imag in the lower half
//     frame_valid  frame complete and stable
//     frame_ready  consumer accepts the frame (only looked at while holding)
//     overrun      sticky: a byte arrived while a frame was held
//     timeout_evt  one-cycle pulse: a partial frame was discarded

// One complex sample slot with independent real/imag byte writes.
module uart_frame_slot #(
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_re,
    input  logic                wr_im,
    input  logic [BYTE_W-1:0]   din,
    output logic [2*BYTE_W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            if (wr_re) q[2*BYTE_W-1:BYTE_W] <= din;
            if (wr_im) q[BYTE_W-1:0]        <= din;
        end
    end
endmodule

module uart_frame_loader #(
    parameter int N_POINTS       = 8,
    parameter int BYTE_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx_valid,
    input  logic [BYTE_W-1:0]              rx_byte,
    output logic [N_POINTS*2*BYTE_W-1:0]   frame_data,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           overrun,
    output logic                           timeout_evt
);
    localparam int LOG2N  = $clog2(N_POINTS);
    localparam int B_W    = LOG2N + 1;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [B_W-1:0]    LAST_BYTE = B_W'(2 * N_POINTS - 1);
    // Counter value on the final idle cycle; the expiry edge is the one that
    // would have taken the count to TIMEOUT_CYCLES.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t              state;
    logic [B_W-1:0]      byte_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic [N_POINTS-1:0][2*BYTE_W-1:0] slot_q;
    logic [LOG2N-1:0]    slot_idx;
    logic                wr_en;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Bytes are only written while filling; anything arriving in HOLD is lost.
    assign wr_en    = (state == FILL) && rx_valid;
    assign slot_idx = bitrev(byte_cnt[B_W-1:1]);

    for (genvar k = 0; k < N_POINTS; k++) begin : g_slot
        logic hit;
        assign hit = wr_en && (slot_idx == LOG2N'(k));

        uart_frame_slot #(
            .BYTE_W (BYTE_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .wr_re (hit && !byte_cnt[0]),
            .wr_im (hit &&  byte_cnt[0]),
            .din   (rx_byte),
            .q     (slot_q[k])
        );
    end

    assign frame_data = slot_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                FILL: begin
                    if (rx_valid) begin
                        // A byte always wins over a coincident timeout expiry.
                        idle_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt    <= '0;
                            state       <= HOLD;
                            frame_valid <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + B_W'(1);
                        end
                    end else if (TIMEOUT_EN && byte_cnt != '0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            // Partial frame dropped; slot contents are left as-is
                            // since the next full frame overwrites every slot.
                            byte_cnt    <= '0;
                            idle_cnt    <= '0;
                            timeout_evt <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                HOLD: begin
                    idle_cnt <= '0;
                    if (rx_valid) overrun <= 1'b1;
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        byte_cnt    <= '0;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;
    localparam int N  = 8;
    localparam int BW = 8;
    localparam int TO = 20;
    localparam int FW = N * 2 * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_valid = 1'b0;
    logic [BW-1:0] rx_byte = '0;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic          overrun;
    logic          timeout_evt;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_tmo  = 0;

    uart_frame_loader #(
        .N_POINTS       (N),
        .BYTE_W         (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is just the 2*N bytes collected while not holding; the expected
    // image puts sample s at slot bitrev(s) with {real, imag}.
    logic [BW-1:0] m_bytes[$];
    logic [FW-1:0] sb_q[$];
    bit            m_held = 0;
    bit            m_ovr  = 0;
    bit            m_tmo  = 0;
    int            m_idle = 0;

    function automatic int rev(input int s);
        int r = 0;
        for (int i = 0; i < $clog2(N); i++)
            if (s & (1 << i)) r |= 1 << ($clog2(N) - 1 - i);
        return r;
    endfunction

    function automatic logic [FW-1:0] build_frame(input logic [BW-1:0] b[$]);
        logic [FW-1:0] f = '0;
        for (int s = 0; s < N; s++)
            f[rev(s)*2*BW +: 2*BW] = {b[2*s], b[2*s+1]};
        return f;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bytes.delete();
            sb_q.delete();
            m_held = 0; m_ovr = 0; m_tmo = 0; m_idle = 0;
        end else begin
            m_tmo = 0;
            if (m_held) begin
                if (rx_valid) m_ovr = 1;
                if (frame_ready) m_held = 0;
            end else if (rx_valid) begin
                m_bytes.push_back(rx_byte);
                m_idle = 0;
                if (m_bytes.size() == 2 * N) begin
                    sb_q.push_back(build_frame(m_bytes));
                    m_bytes.delete();
                    m_held = 1;
                end
            end else if (m_bytes.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_bytes.delete();
                    m_idle = 0;
                    m_tmo  = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [FW-1:0] cur_exp = '0;
    logic          prev_fv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("frame_valid", FW'(frame_valid), FW'(m_held));
            chk("overrun", FW'(overrun), FW'(m_ovr));
            chk("timeout_evt", FW'(timeout_evt), FW'(m_tmo));
            if (timeout_evt) n_tmo++;
            if (frame_valid && !prev_fv) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL sb_empty: got frame_valid 1 want no frame pending");
                end else begin
                    cur_exp = sb_q.pop_front();
                end
            end
            if (frame_valid) chk("frame_data", frame_data, cur_exp);
            prev_fv = frame_valid;
        end else begin
            prev_fv = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [BW-1:0] b, input logic r);
        rx_valid = v; rx_byte = b; frame_ready = r;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_ready = 1'b0;
    endtask

    task automatic send_seq(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b1, BW'(first + i), 1'b0);
    endtask

    function automatic logic [FW-1:0] slot(input int k);
        return FW'(frame_data[k*2*BW +: 2*BW]);
    endfunction

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", frame_data, '0);
        chk("rst_valid", FW'(frame_valid), '0);
        chk("rst_ovr", FW'(overrun), '0);
        chk("rst_tmo", FW'(timeout_evt), '0);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);

        // Frame of 0x00..0x0F, checked against fixed expected slots.
        send_seq(8'h00, 15);
        chk("pre_valid", FW'(frame_valid), '0);
        send_seq(8'h0F, 1);
        chk("t1_valid", FW'(frame_valid), 1);
        chk("t1_s0", slot(0), 16'h0001);
        chk("t1_s4", slot(4), 16'h0203);
        chk("t1_s2", slot(2), 16'h0405);
        chk("t1_s6", slot(6), 16'h0607);
        chk("t1_s1", slot(1), 16'h0809);
        chk("t1_s5", slot(5), 16'h0A0B);
        chk("t1_s3", slot(3), 16'h0C0D);
        chk("t1_s7", slot(7), 16'h0E0F);
        chk("t1_ovr", FW'(overrun), '0);

        // Long hold with a stray byte, then a byte in the accept cycle.
        for (int i = 0; i < 50; i++) cyc(i == 20, 8'hAA, 1'b0);
        chk("t2_ovr", FW'(overrun), 1);
        cyc(1'b1, 8'hAA, 1'b1);
        chk("t2_acc", FW'(frame_valid), '0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h66, 1'b0);
        send_seq(8'h40, 14);
        chk("t3_s0", slot(0), 16'h5566);
        chk("t3_ovr", FW'(overrun), 1);
        cyc(1'b0, '0, 1'b1);

        // Timeout after 5 bytes and 20 idle cycles.
        t0 = n_tmo;
        send_seq(8'h80, 5);
        repeat (TO) cyc(1'b0, '0, 1'b0);
        chk("t4_evt", FW'(timeout_evt), 1);
        cyc(1'b0, '0, 1'b0);
        chk("t4_once", FW'(n_tmo - t0), 1);
        send_seq(8'h10, 16);
        chk("t4_s0", slot(0), 16'h1011);
        chk("t4_s7", slot(7), 16'h1E1F);
        chk("t4_valid", FW'(frame_valid), 1);
        cyc(1'b0, '0, 1'b1);

        // Byte coincides with the would-be expiry edge.
        t0 = n_tmo;
        send_seq(8'h20, 5);
        repeat (TO - 1) cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        send_seq(8'h26, 10);
        chk("t5_no_tmo", FW'(n_tmo - t0), '0);
        chk("t5_s2", slot(2), 16'h2477);
        cyc(1'b0, '0, 1'b1);

        // Asynchronous reset mid-frame.
        send_seq(8'hC0, 9);
        #2 rst = 1'b0;
        #1;
        chk("t6_data", frame_data, '0);
        chk("t6_valid", FW'(frame_valid), '0);
        chk("t6_ovr", FW'(overrun), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        send_seq(8'h30, 16);
        chk("t6_s0", slot(0), 16'h3031);
        chk("t6_s7", slot(7), 16'h3E3F);
        cyc(1'b0, '0, 1'b1);

        // Randomised traffic with occasional long gaps.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                int gap = $urandom_range(TO - 2, TO + 3);
                repeat (gap) cyc(1'b0, '0, $urandom_range(0, 99) < 15);
            end
            cyc($urandom_range(0, 99) < 60, BW'($urandom), $urandom_range(0, 99) < 15);
        end
        repeat (3) cyc(1'b0, '0, 1'b0);
        chk("sb_drain", FW'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
